// File: rtl/rf_writeback_arbiter_if.sv
// Bundle of result sources, write port and scoreboard for the writeback arbiter.
// WB_FWD_EN adds decode-side forwarding signals.
interface rf_writeback_arbiter_if #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_val;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_val;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   rd;
    logic            rd_write_control;
    logic [XLEN-1:0] rd_write_val;
    logic [NREG-1:0] pending;
    logic [CW-1:0]   fifo_count;
`ifdef WB_FWD_EN
    logic [AW-1:0]   fwd_rs1;
    logic [AW-1:0]   fwd_rs2;
    logic            fwd_rs1_hit;
    logic            fwd_rs2_hit;
    logic [XLEN-1:0] fwd_val;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_val,
        input  lsu_valid, lsu_rd, lsu_val,
        input  iss_valid, iss_rd,
        output lsu_ready, rd, rd_write_control,
        output rd_write_val, pending, fifo_count
`ifdef WB_FWD_EN
        , input  fwd_rs1, fwd_rs2
        , output fwd_rs1_hit, fwd_rs2_hit, fwd_val
`endif
    );

    modport master (
        output alu_valid, alu_rd, alu_val,
        output lsu_valid, lsu_rd, lsu_val,
        output iss_valid, iss_rd,
        input  lsu_ready, rd, rd_write_control,
        input  rd_write_val, pending, fifo_count
`ifdef WB_FWD_EN
        , output fwd_rs1, fwd_rs2
        , input  fwd_rs1_hit, fwd_rs2_hit, fwd_val
`endif
    );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU and long-latency results onto the register-file write port.
// Optional macro WB_FWD_EN exposes a decode bypass off the registered port.
module rf_writeback_arbiter #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic                   i_clk,
    input logic                   i_rst,
    rf_writeback_arbiter_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [AW-1:0]   q_rd  [FIFO_DEPTH];
    logic [XLEN-1:0] q_val [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [AW-1:0]   wb_rd;
    logic            wb_we;
    logic [XLEN-1:0] wb_val;
    logic            push;
    logic            pop;
    logic            alu_take;

    assign bus.lsu_ready = !i_rst && (count < FULL);
    // x0 results complete the handshake but never occupy a slot
    assign push     = bus.lsu_valid && bus.lsu_ready
                   && (bus.lsu_rd != '0);
    assign alu_take = bus.alu_valid && (bus.alu_rd != '0);
    assign pop      = !alu_take && (count != '0);

    always_comb begin
        pend_nxt = pend;
        if (pop)
            pend_nxt[q_rd[rd_ptr]] = 1'b0;
        if (bus.iss_valid)
            pend_nxt[bus.iss_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            q_rd[wr_ptr]  <= bus.lsu_rd;
            q_val[wr_ptr] <= bus.lsu_val;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            pend   <= '0;
            wb_rd  <= '0;
            wb_we  <= 1'b0;
            wb_val <= '0;
        end else begin
            pend <= pend_nxt;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            unique case (1'b1)
                alu_take: begin
                    wb_rd  <= bus.alu_rd;
                    wb_val <= bus.alu_val;
                    wb_we  <= 1'b1;
                end
                pop: begin
                    wb_rd  <= q_rd[rd_ptr];
                    wb_val <= q_val[rd_ptr];
                    wb_we  <= 1'b1;
                end
                default: wb_we <= 1'b0;
            endcase
        end
    end

    assign bus.rd               = wb_rd;
    assign bus.rd_write_control = wb_we;
    assign bus.rd_write_val     = wb_val;
    assign bus.pending          = pend;
    assign bus.fifo_count       = count;

`ifdef WB_FWD_EN
    assign bus.fwd_rs1_hit = wb_we && (wb_rd == bus.fwd_rs1)
                          && (bus.fwd_rs1 != '0);
    assign bus.fwd_rs2_hit = wb_we && (wb_rd == bus.fwd_rs2)
                          && (bus.fwd_rs2 != '0);
    assign bus.fwd_val     = wb_val;
`endif
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: reset, ALU path, FIFO path,
// full/drain ordering, x0 handling, scoreboard collision, mid-run reset.
module tb_rf_writeback_arbiter;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int FD   = 4;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    rf_writeback_arbiter_if #(.XLEN(XLEN), .NREG(NREG), .FIFO_DEPTH(FD)) bus ();

    rf_writeback_arbiter #(.XLEN(XLEN), .NREG(NREG), .FIFO_DEPTH(FD)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    task automatic idle();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_val = 0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_val = 0;
        bus.iss_valid = 0; bus.iss_rd = 0;
`ifdef WB_FWD_EN
        bus.fwd_rs1 = 0; bus.fwd_rs2 = 0;
`endif
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        i_rst = 1;
        tick();
        tick();
        checks++;
        if (bus.rd_write_control !== 1'b0) begin
            $display("FAIL rst_we got %b want 0", bus.rd_write_control); fails++;
        end
        checks++;
        if (bus.rd !== 5'd0 || bus.rd_write_val !== 32'd0) begin
            $display("FAIL rst_port got rd=%0d val=%h want 0/0", bus.rd, bus.rd_write_val); fails++;
        end
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.pending !== 32'd0) begin
            $display("FAIL rst_state got cnt=%0d pend=%h want 0/0", bus.fifo_count, bus.pending); fails++;
        end
        checks++;
        if (bus.lsu_ready !== 1'b0) begin
            $display("FAIL rst_ready got %b want 0", bus.lsu_ready); fails++;
        end
        i_rst = 0;
        #1;
        checks++;
        if (bus.lsu_ready !== 1'b1) begin
            $display("FAIL ready_after_rst got %b want 1", bus.lsu_ready); fails++;
        end
    endtask

    task automatic test_alu();
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_val = 32'h1234_5678;
        tick();
        bus.alu_valid = 0;
        checks++;
        if (bus.rd_write_control !== 1'b1 || bus.rd !== 5'd5 || bus.rd_write_val !== 32'h1234_5678) begin
            $display("FAIL alu_write got we=%b rd=%0d val=%h want 1/5/12345678",
                     bus.rd_write_control, bus.rd, bus.rd_write_val); fails++;
        end
`ifdef WB_FWD_EN
        bus.fwd_rs1 = 5; bus.fwd_rs2 = 6;
        #1;
        checks++;
        if (bus.fwd_rs1_hit !== 1'b1 || bus.fwd_rs2_hit !== 1'b0 || bus.fwd_val !== 32'h1234_5678) begin
            $display("FAIL fwd got h1=%b h2=%b val=%h want 1/0/12345678",
                     bus.fwd_rs1_hit, bus.fwd_rs2_hit, bus.fwd_val); fails++;
        end
        bus.fwd_rs1 = 0; bus.fwd_rs2 = 0;
`endif
        tick();
        checks++;
        if (bus.rd_write_control !== 1'b0 || bus.rd !== 5'd5) begin
            $display("FAIL alu_idle got we=%b rd=%0d want 0/5", bus.rd_write_control, bus.rd); fails++;
        end
    endtask

    task automatic test_lsu();
        bus.iss_valid = 1; bus.iss_rd = 7;
        tick();
        bus.iss_valid = 0;
        checks++;
        if (bus.pending !== 32'h0000_0080) begin
            $display("FAIL iss_set got %h want 00000080", bus.pending); fails++;
        end
        tick();
        bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_val = 32'hDEAD_BEEF;
        tick();
        bus.lsu_valid = 0;
        checks++;
        if (bus.rd_write_control !== 1'b0 || bus.fifo_count !== 3'd1 || bus.pending !== 32'h80) begin
            $display("FAIL lsu_no_bypass got we=%b cnt=%0d pend=%h want 0/1/80",
                     bus.rd_write_control, bus.fifo_count, bus.pending); fails++;
        end
        tick();
        checks++;
        if (bus.rd_write_control !== 1'b1 || bus.rd !== 5'd7 || bus.rd_write_val !== 32'hDEAD_BEEF) begin
            $display("FAIL lsu_write got we=%b rd=%0d val=%h want 1/7/deadbeef",
                     bus.rd_write_control, bus.rd, bus.rd_write_val); fails++;
        end
        checks++;
        if (bus.pending !== 32'd0 || bus.fifo_count !== 3'd0) begin
            $display("FAIL lsu_clear got pend=%h cnt=%0d want 0/0", bus.pending, bus.fifo_count); fails++;
        end
    endtask

    task automatic test_full();
        bus.alu_valid = 1; bus.alu_rd = 9; bus.alu_val = 32'h0000_0999;
        for (int i = 1; i <= 4; i++) begin
            bus.lsu_valid = 1; bus.lsu_rd = 5'(i); bus.lsu_val = 32'h100 + i;
            tick();
            checks++;
            if (bus.rd_write_control !== 1'b1 || bus.rd !== 5'd9 || bus.rd_write_val !== 32'h999) begin
                $display("FAIL full_alu%0d got we=%b rd=%0d val=%h want 1/9/999",
                         i, bus.rd_write_control, bus.rd, bus.rd_write_val); fails++;
            end
        end
        bus.lsu_rd = 5'd20; bus.lsu_val = 32'h0BAD;
        #1;
        checks++;
        if (bus.lsu_ready !== 1'b0 || bus.fifo_count !== 3'd4) begin
            $display("FAIL full_flag got rdy=%b cnt=%0d want 0/4", bus.lsu_ready, bus.fifo_count); fails++;
        end
        tick();
        checks++;
        if (bus.fifo_count !== 3'd4) begin
            $display("FAIL full_reject got cnt=%0d want 4", bus.fifo_count); fails++;
        end
        bus.lsu_valid = 0; bus.alu_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (bus.rd_write_control !== 1'b1 || bus.rd !== 5'(i) || bus.rd_write_val !== 32'h100 + i) begin
                $display("FAIL drain%0d got we=%b rd=%0d val=%h want 1/%0d/%h",
                         i, bus.rd_write_control, bus.rd, bus.rd_write_val, i, 32'h100 + i); fails++;
            end
            if (i == 1) begin
                checks++;
                if (bus.lsu_ready !== 1'b1 || bus.fifo_count !== 3'd3) begin
                    $display("FAIL ready_after_pop got rdy=%b cnt=%0d want 1/3",
                             bus.lsu_ready, bus.fifo_count); fails++;
                end
            end
        end
        tick();
        checks++;
        if (bus.rd_write_control !== 1'b0 || bus.fifo_count !== 3'd0) begin
            $display("FAIL drained got we=%b cnt=%0d want 0/0", bus.rd_write_control, bus.fifo_count); fails++;
        end
    endtask

    task automatic test_zero_reg();
        bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_val = 32'h0BAD;
        #1;
        checks++;
        if (bus.lsu_ready !== 1'b1) begin
            $display("FAIL x0_push_ready got %b want 1", bus.lsu_ready); fails++;
        end
        tick();
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.rd_write_control !== 1'b0) begin
            $display("FAIL x0_push got cnt=%0d we=%b want 0/0", bus.fifo_count, bus.rd_write_control); fails++;
        end
        bus.lsu_rd = 3; bus.lsu_val = 32'h0000_0033;
        bus.alu_valid = 1; bus.alu_rd = 9; bus.alu_val = 32'h0999;
        tick();
        bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_val = 32'h0BAD;
        bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_val = 32'h0BAD;
        bus.iss_valid = 1; bus.iss_rd = 0;
        tick();
        idle();
        checks++;
        if (bus.rd_write_control !== 1'b1 || bus.rd !== 5'd3 || bus.rd_write_val !== 32'h33) begin
            $display("FAIL x0_alu_pop got we=%b rd=%0d val=%h want 1/3/33",
                     bus.rd_write_control, bus.rd, bus.rd_write_val); fails++;
        end
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.pending !== 32'd0) begin
            $display("FAIL x0_state got cnt=%0d pend=%h want 0/0", bus.fifo_count, bus.pending); fails++;
        end
    endtask

    task automatic test_collision();
        bus.iss_valid = 1; bus.iss_rd = 6;
        tick();
        bus.iss_valid = 0;
        bus.lsu_valid = 1; bus.lsu_rd = 6; bus.lsu_val = 32'h66;
        bus.alu_valid = 1; bus.alu_rd = 9;
        tick();
        bus.lsu_valid = 0; bus.alu_valid = 0;
        bus.iss_valid = 1; bus.iss_rd = 6;
        tick();
        bus.iss_valid = 0;
        checks++;
        if (bus.rd_write_control !== 1'b1 || bus.rd !== 5'd6 || bus.pending !== 32'h40) begin
            $display("FAIL collide got we=%b rd=%0d pend=%h want 1/6/40",
                     bus.rd_write_control, bus.rd, bus.pending); fails++;
        end
    endtask

    task automatic test_reset_mid();
        bus.alu_valid = 1; bus.alu_rd = 9;
        for (int i = 0; i < 4; i++) begin
            bus.iss_valid = 1; bus.iss_rd = 5'(4 + i);
            bus.lsu_valid = (i < 3); bus.lsu_rd = 5'(4 + i); bus.lsu_val = 32'hA0 + i;
            tick();
        end
        idle();
        checks++;
        if (bus.fifo_count !== 3'd3 || bus.pending !== 32'h0000_00F0) begin
            $display("FAIL pre_rst got cnt=%0d pend=%h want 3/f0", bus.fifo_count, bus.pending); fails++;
        end
        i_rst = 1;
        tick();
        i_rst = 0;
        checks++;
        if (bus.fifo_count !== 3'd0 || bus.pending !== 32'd0 || bus.rd_write_control !== 1'b0) begin
            $display("FAIL mid_rst got cnt=%0d pend=%h we=%b want 0/0/0",
                     bus.fifo_count, bus.pending, bus.rd_write_control); fails++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.rd_write_control !== 1'b0) begin
                $display("FAIL post_rst%0d got we=%b want 0", i, bus.rd_write_control); fails++;
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_alu();
        test_lsu();
        test_full();
        test_zero_reg();
        test_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
